// File: rtl/tt_um_seq_subtractor.sv
// Sequential unsigned subtractor (A - B mod 256), LSB-first, BITS_PER_CYCLE bits per clock.
// Latency N = 8/BITS_PER_CYCLE active cycles from the start edge; ena=0 freezes everything.
module tt_um_seq_subtractor #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int B = BITS_PER_CYCLE;
  localparam int N = 8 / BITS_PER_CYCLE;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t     r_state;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [7:0] r_sa;
  logic [7:0] r_sb;
  logic [7:0] r_acc;
  logic [7:0] r_result;
  logic [3:0] r_cnt;
  logic       r_chain;
  logic       r_borrow;
  logic       r_zero;
  logic       r_busy;
  logic       r_done;
  logic       r_start_q;

  logic       w_start_evt;
  logic [B:0] w_diff;
  logic [7+B:0] w_cat;
  logic [7:0] w_acc_next;
  logic       w_unused;

  assign w_start_evt = uio_in[2] & ~r_start_q;
  assign w_unused    = &{1'b0, uio_in[7:3]};

  // Chunk difference; the extra top bit of w_diff is the borrow out.
  // New chunks enter at the top of the accumulator and shift down, so after
  // N cycles the first chunk sits at bit 0.
  always_comb begin
    w_diff     = {1'b0, r_sa[B-1:0]} - {1'b0, r_sb[B-1:0]} - {{B{1'b0}}, r_chain};
    w_cat      = {w_diff[B-1:0], r_acc};
    w_acc_next = w_cat[7+B:B];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_a       <= 8'h00;
      r_b       <= 8'h00;
      r_sa      <= 8'h00;
      r_sb      <= 8'h00;
      r_acc     <= 8'h00;
      r_result  <= 8'h00;
      r_cnt     <= 4'd0;
      r_chain   <= 1'b0;
      r_borrow  <= 1'b0;
      r_zero    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_start_q <= 1'b0;
    end else if (ena) begin
      r_start_q <= uio_in[2];
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_evt) begin
            r_sa    <= r_a;
            r_sb    <= r_b;
            r_chain <= 1'b0;
            r_cnt   <= 4'd0;
            r_acc   <= 8'h00;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_state <= S_RUN;
          end else if (uio_in[0] | uio_in[1]) begin
            if (uio_in[0]) r_a <= ui_in;
            if (uio_in[1]) r_b <= ui_in;
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_sa    <= r_sa >> B;
          r_sb    <= r_sb >> B;
          r_chain <= w_diff[B];
          r_acc   <= w_acc_next;
          r_cnt   <= r_cnt + 4'd1;
          if (r_cnt == 4'(N - 1)) begin
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= w_acc_next;
            r_borrow <= w_diff[B];
            r_zero   <= (w_acc_next == 8'h00);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign uo_out  = r_result;
  assign uio_out = {r_busy, r_done, r_borrow, r_zero, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule
